// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types, range limits and helpers for the traffic phase controller
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_MANUAL = 2'd3
    } tlc_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int TIME_MIN  = 1;
    localparam int TIME_MAX  = 99;
    localparam int N_WAY_MIN = 2;
    localparam int N_WAY_MAX = 8;

    // True when a seconds value fits the two-digit display and is non-zero
    function automatic logic time_ok(input int t);
        return (t >= TIME_MIN) && (t <= TIME_MAX);
    endfunction

    // Binary 0..99 to packed {tens, units} BCD; only used on constants
    function automatic logic [7:0] to_bcd(input int v);
        int t;
        int u;
        t = v / 10;
        u = v % 10;
        return {t[3:0], u[3:0]};
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - two-digit BCD countdown with load, decrement and 00/01 detect
module bcd_down_counter
    import traffic_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h01
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output bcd_digit_t o_tens,
    output bcd_digit_t o_units,
    output logic       o_zero,
    output logic       o_one
);

    bcd_digit_t r_tens;
    bcd_digit_t r_units;
    logic       w_zero;

    assign w_zero  = (r_tens == 4'd0) && (r_units == 4'd0);
    assign o_zero  = w_zero;
    assign o_one   = (r_tens == 4'd0) && (r_units == 4'd1);
    assign o_tens  = r_tens;
    assign o_units = r_units;

    // Load wins over decrement; the count never wraps below 00
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tens  <= RST_VAL[7:4];
            r_units <= RST_VAL[3:0];
        end else if (i_load) begin
            r_tens  <= i_load_val[7:4];
            r_units <= i_load_val[3:0];
        end else if (i_dec && !w_zero) begin
            if (r_units == 4'd0) begin
                r_units <= 4'd9;
                r_tens  <= r_tens - 4'd1;
            end else begin
                r_units <= r_units - 4'd1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - N-way signal phase controller; TLC_SKIP_IDLE_EN enables idle-approach skipping
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_WAY       = 2,
    parameter int TICK_DIV    = 50000000,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 3,
    parameter int CLEAR_TIME  = 1,
    parameter int EXT_TIME    = 10,
    parameter int MAX_GREEN   = 60
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [N_WAY-1:0]           Traffic,
    input  logic [N_WAY-1:0]           Manual,
    output logic [N_WAY-1:0]           Green,
    output logic [N_WAY-1:0]           Yellow,
    output logic [N_WAY-1:0]           Red,
    output logic [$clog2(N_WAY)-1:0]   Phase,
    output logic [3:0]                 Time_H,
    output logic [3:0]                 Time_L,
    output logic                       Man_Act
);

    localparam int PW  = $clog2(N_WAY);
    localparam int PRW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] LD_GREEN  = to_bcd(GREEN_TIME);
    localparam logic [7:0] LD_YELLOW = to_bcd(YELLOW_TIME);
    localparam logic [7:0] LD_CLEAR  = to_bcd(CLEAR_TIME);
    localparam logic [7:0] LD_EXT    = to_bcd(EXT_TIME);
    localparam logic [7:0] LD_HOLD   = 8'h00;

    if (N_WAY < N_WAY_MIN || N_WAY > N_WAY_MAX || TICK_DIV < 1 ||
        !time_ok(GREEN_TIME) || !time_ok(YELLOW_TIME) || !time_ok(CLEAR_TIME) ||
        !time_ok(EXT_TIME) || !time_ok(MAX_GREEN) || MAX_GREEN < GREEN_TIME) begin : g_bad_param
        $error("traffic_phase_ctrl: illegal parameter set");
    end

    tlc_state_t       r_state;
    tlc_state_t       w_state_nxt;
    logic [PW-1:0]    r_phase;
    logic [PW-1:0]    w_phase_nxt;
    logic [PW-1:0]    r_nxt;
    logic [PW-1:0]    w_nxt_nxt;
    logic [PW-1:0]    w_rr;
    logic [PW-1:0]    w_nxt_sel;
    logic [PW-1:0]    w_req;
    logic             w_req_vld;
    logic [PRW-1:0]   r_presc;
    logic             w_tick;
    logic             w_end;
    logic             w_load;
    logic [7:0]       w_load_val;
    logic [6:0]       r_elapsed;
    logic [6:0]       w_elapsed_nxt;
    logic             w_ext_ok;
    logic [N_WAY-1:0] w_onehot;
    logic [N_WAY-1:0] w_green_nxt;
    logic [N_WAY-1:0] w_yellow_nxt;
    logic [N_WAY-1:0] r_green;
    logic [N_WAY-1:0] r_yellow;
    logic [N_WAY-1:0] r_red;
    logic             r_man_act;
    bcd_digit_t       w_tens;
    bcd_digit_t       w_units;
    logic             w_zero;
    logic             w_one;

    assign w_tick   = (r_presc == PRW'(TICK_DIV - 1));
    assign w_end    = w_tick && w_one;
    assign w_ext_ok = ({1'b0, r_elapsed} + 8'(EXT_TIME)) <= 8'(MAX_GREEN);
    assign w_rr     = (r_phase == PW'(N_WAY - 1)) ? '0 : r_phase + PW'(1);

    // Lowest set Manual bit is the effective request
    always_comb begin
        w_req_vld = |Manual;
        w_req     = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (Manual[i]) w_req = PW'(i);
        end
    end

`ifdef TLC_SKIP_IDLE_EN
    logic [2*N_WAY-1:0] w_tr_rot;
    logic [PW:0]        w_shamt;
    logic [PW:0]        w_sum;
    logic               w_found;

    // Pick the first approach after the current one that has traffic waiting
    always_comb begin
        w_shamt   = {1'b0, r_phase} + (PW+1)'(1);
        w_tr_rot  = {Traffic, Traffic} >> w_shamt;
        w_nxt_sel = w_rr;
        w_found   = 1'b0;
        w_sum     = '0;
        for (int k = 0; k < N_WAY - 1; k++) begin
            if (!w_found && w_tr_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_phase} + (PW+1)'(k + 1);
                if (w_sum >= (PW+1)'(N_WAY)) w_sum = w_sum - (PW+1)'(N_WAY);
                w_nxt_sel = w_sum[PW-1:0];
            end
        end
    end
`else
    assign w_nxt_sel = w_rr;
`endif

    // Next-state decision: manual requests take priority over phase expiry and extension
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_nxt_nxt     = r_nxt;
        w_elapsed_nxt = r_elapsed;
        w_load        = 1'b0;
        w_load_val    = LD_HOLD;
        case (r_state)
            ST_CLEAR: begin
                if (w_end) begin
                    w_load = 1'b1;
                    if (w_req_vld) begin
                        w_state_nxt = ST_MANUAL;
                        w_phase_nxt = w_req;
                        w_load_val  = LD_HOLD;
                    end else begin
                        w_state_nxt   = ST_GREEN;
                        w_phase_nxt   = r_nxt;
                        w_load_val    = LD_GREEN;
                        w_elapsed_nxt = 7'(GREEN_TIME);
                    end
                end
            end
            ST_GREEN: begin
                if (w_req_vld && (w_req == r_phase)) begin
                    w_state_nxt = ST_MANUAL;
                    w_load      = 1'b1;
                    w_load_val  = LD_HOLD;
                end else if (w_req_vld) begin
                    w_state_nxt = ST_YELLOW;
                    w_load      = 1'b1;
                    w_load_val  = LD_YELLOW;
                end else if (w_end) begin
                    w_load = 1'b1;
                    if (Traffic[r_phase] && w_ext_ok) begin
                        w_load_val    = LD_EXT;
                        w_elapsed_nxt = r_elapsed + 7'(EXT_TIME);
                    end else begin
                        w_state_nxt = ST_YELLOW;
                        w_load_val  = LD_YELLOW;
                    end
                end
            end
            ST_YELLOW: begin
                if (w_end) begin
                    w_state_nxt = ST_CLEAR;
                    w_load      = 1'b1;
                    w_load_val  = LD_CLEAR;
                    w_nxt_nxt   = w_nxt_sel;
                end
            end
            default: begin
                if (!w_req_vld || (w_req != r_phase)) begin
                    w_state_nxt = ST_YELLOW;
                    w_load      = 1'b1;
                    w_load_val  = LD_YELLOW;
                end
            end
        endcase
    end

    // Lamp pattern for the state being entered, so lamps change on the same edge as the state
    always_comb begin
        w_onehot     = {{(N_WAY-1){1'b0}}, 1'b1} << w_phase_nxt;
        w_green_nxt  = '0;
        w_yellow_nxt = '0;
        if (w_state_nxt == ST_GREEN || w_state_nxt == ST_MANUAL) w_green_nxt = w_onehot;
        if (w_state_nxt == ST_YELLOW) w_yellow_nxt = w_onehot;
    end

    // Phase FSM, prescaler and registered lamp outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= ST_CLEAR;
            r_phase   <= '0;
            r_nxt     <= '0;
            r_elapsed <= '0;
            r_presc   <= '0;
            r_green   <= '0;
            r_yellow  <= '0;
            r_red     <= '1;
            r_man_act <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_nxt     <= w_nxt_nxt;
            r_elapsed <= w_elapsed_nxt;
            if (w_load || w_tick || w_state_nxt == ST_MANUAL) r_presc <= '0;
            else r_presc <= r_presc + PRW'(1);
            r_green   <= w_green_nxt;
            r_yellow  <= w_yellow_nxt;
            r_red     <= ~(w_green_nxt | w_yellow_nxt);
            r_man_act <= (w_state_nxt == ST_MANUAL);
        end
    end

    bcd_down_counter #(
        .RST_VAL (LD_CLEAR)
    ) u_count (
        .i_clk      (Clk),
        .i_rst_n    (Rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_tick && !w_load && !w_zero),
        .o_tens     (w_tens),
        .o_units    (w_units),
        .o_zero     (w_zero),
        .o_one      (w_one)
    );

    assign Green   = r_green;
    assign Yellow  = r_yellow;
    assign Red     = r_red;
    assign Phase   = r_phase;
    assign Time_H  = w_tens;
    assign Time_L  = w_units;
    assign Man_Act = r_man_act;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed vector bench for traffic_phase_ctrl (N_WAY=3, TICK_DIV=4)
module tb_traffic_phase_ctrl;

    logic       Clk;
    logic       Rst_n;
    logic [2:0] Traffic;
    logic [2:0] Manual;
    logic [2:0] Green;
    logic [2:0] Yellow;
    logic [2:0] Red;
    logic [1:0] Phase;
    logic [3:0] Time_H;
    logic [3:0] Time_L;
    logic       Man_Act;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        int          wcyc;
        logic [2:0]  tr;
        logic [2:0]  mn;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    traffic_phase_ctrl #(
        .N_WAY       (3),
        .TICK_DIV    (4),
        .GREEN_TIME  (5),
        .YELLOW_TIME (2),
        .CLEAR_TIME  (1),
        .EXT_TIME    (3),
        .MAX_GREEN   (8)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Traffic (Traffic),
        .Manual  (Manual),
        .Green   (Green),
        .Yellow  (Yellow),
        .Red     (Red),
        .Phase   (Phase),
        .Time_H  (Time_H),
        .Time_L  (Time_L),
        .Man_Act (Man_Act)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [19:0] pk(input logic [2:0] g, input logic [2:0] y, input logic [2:0] r,
                                       input logic [1:0] p, input logic [7:0] t, input logic m);
        return {g, y, r, p, t, m};
    endfunction

    function automatic logic [19:0] act();
        return {Green, Yellow, Red, Phase, Time_H, Time_L, Man_Act};
    endfunction

    task automatic check(input string name, input logic [19:0] a, input logic [19:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got G=%b Y=%b R=%b P=%0d T=%h M=%b, expected G=%b Y=%b R=%b P=%0d T=%h M=%b",
                     name, a[19:17], a[16:14], a[13:11], a[10:9], a[8:1], a[0],
                     e[19:17], e[16:14], e[13:11], e[10:9], e[8:1], e[0]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic add(input logic rst, input int w, input logic [2:0] tr, input logic [2:0] mn,
                       input logic [19:0] e);
        vec_t v;
        v.rst  = rst;
        v.wcyc = w;
        v.tr   = tr;
        v.mn   = mn;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    initial begin
        int bad;
        Rst_n   = 1'b0;
        Traffic = 3'b000;
        Manual  = 3'b000;

        // plain rotation from reset
        add(1, 0,  3'b000, 3'b000, pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));
        add(0, 3,  3'b000, 3'b000, pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));
        add(0, 1,  3'b000, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h05, 1'b0));
        add(0, 3,  3'b000, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h05, 1'b0));
        add(0, 1,  3'b000, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h04, 1'b0));
        add(0, 15, 3'b000, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h01, 1'b0));
        add(0, 1,  3'b000, 3'b000, pk(3'b000, 3'b001, 3'b110, 2'd0, 8'h02, 1'b0));
        add(0, 7,  3'b000, 3'b000, pk(3'b000, 3'b001, 3'b110, 2'd0, 8'h01, 1'b0));
        add(0, 1,  3'b000, 3'b000, pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));
        add(0, 3,  3'b000, 3'b000, pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));
        add(0, 1,  3'b000, 3'b000, pk(3'b010, 3'b000, 3'b101, 2'd1, 8'h05, 1'b0));
        // one extension granted (5+3=8), the second denied (11>8)
        add(1, 4,  3'b001, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h05, 1'b0));
        add(0, 20, 3'b001, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h03, 1'b0));
        add(0, 11, 3'b001, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h01, 1'b0));
        add(0, 1,  3'b001, 3'b000, pk(3'b000, 3'b001, 3'b110, 2'd0, 8'h02, 1'b0));
        // manual request for way2 cuts way0 green at 03, then hold and release
        add(1, 4,  3'b000, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h05, 1'b0));
        add(0, 8,  3'b000, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h03, 1'b0));
        add(0, 1,  3'b000, 3'b100, pk(3'b000, 3'b001, 3'b110, 2'd0, 8'h02, 1'b0));
        add(0, 8,  3'b000, 3'b100, pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));
        add(0, 4,  3'b000, 3'b100, pk(3'b100, 3'b000, 3'b011, 2'd2, 8'h00, 1'b1));
        add(0, 10, 3'b000, 3'b100, pk(3'b100, 3'b000, 3'b011, 2'd2, 8'h00, 1'b1));
        add(0, 1,  3'b000, 3'b000, pk(3'b000, 3'b100, 3'b011, 2'd2, 8'h02, 1'b0));
        add(0, 8,  3'b000, 3'b000, pk(3'b000, 3'b000, 3'b111, 2'd2, 8'h01, 1'b0));
        add(0, 4,  3'b000, 3'b000, pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h05, 1'b0));

        // reset value while Rst_n is still low
        @(posedge Clk);
        #1;
        check("reset_held", act(), pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));

        foreach (tbl[i]) begin
            Traffic = tbl[i].tr;
            Manual  = tbl[i].mn;
            if (tbl[i].rst) pulse_reset();
            step(tbl[i].wcyc);
            check($sformatf("vec%0d", i), act(), tbl[i].exp);
        end

        // lowest index wins; way1 must stay dark throughout
        Traffic = 3'b000;
        Manual  = 3'b000;
        pulse_reset();
        step(68);
        check("lowidx_way2_green", act(), pk(3'b100, 3'b000, 3'b011, 2'd2, 8'h05, 1'b0));
        Manual = 3'b011;
        step(1);
        check("lowidx_cut_yellow", act(), pk(3'b000, 3'b100, 3'b011, 2'd2, 8'h02, 1'b0));
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (Green[1] !== 1'b0) bad++;
        end
        check("lowidx_way0_manual", act(), pk(3'b001, 3'b000, 3'b110, 2'd0, 8'h00, 1'b1));
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL lowidx_way1_dark: way1 green in %0d cycles, required 0", bad);
        end
        Manual = 3'b000;

        // asynchronous reset in the middle of yellow
        pulse_reset();
        step(26);
        check("midyellow_pre", act(), pk(3'b000, 3'b001, 3'b110, 2'd0, 8'h02, 1'b0));
        #3;
        Rst_n = 1'b0;
        #1;
        check("midyellow_async_rst", act(), pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // traffic only on way2: successor of way0
        Traffic = 3'b100;
        pulse_reset();
        step(32);
        check("skip_clear", act(), pk(3'b000, 3'b000, 3'b111, 2'd0, 8'h01, 1'b0));
        step(4);
`ifdef TLC_SKIP_IDLE_EN
        check("skip_next_green", act(), pk(3'b100, 3'b000, 3'b011, 2'd2, 8'h05, 1'b0));
`else
        check("skip_next_green", act(), pk(3'b010, 3'b000, 3'b101, 2'd1, 8'h05, 1'b0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
